// File: rtl/imm_extend_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry immediate-extension
// result register (decode stage and branch-target precompute share one extender).
`timescale 1ns/1ps

module imm_extend_arbiter #(
  parameter int unsigned ILLEGAL_ZERO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  input  logic [31:0] in0_instr,
  output logic        in0_ready,
  input  logic        in1_valid,
  input  logic [31:0] in1_instr,
  output logic        in1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic        out_src,
  output logic [1:0]  out_mode,
  output logic        out_illegal,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_SIGN = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_LUI  = 2'b10;

  state_t      r_state;
  logic        r_last_grant;
  logic [31:0] r_imm;
  logic        r_src;
  logic [1:0]  r_mode;
  logic        r_illegal;

  logic        w_accept_ok;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [5:0]  w_opcode;
  logic [15:0] w_imm16;
  logic [31:0] w_ext_imm;
  logic [1:0]  w_ext_mode;
  logic        w_ext_illegal;
  logic        w_unused;

  // Handshakes are valid/ready: a transfer happens on the rising edge where both
  // are high. Requesters may change or drop valid freely; readiness depends on
  // valid through the grant, and no ready is ever raised while reset is held.
  assign w_accept_ok = rst & ((r_state == ST_EMPTY) | out_ready);

  // Round-robin: on a tie the requester that did not win last time is granted.
  assign w_grant0 = in0_valid & (~in1_valid | r_last_grant);
  assign w_grant1 = in1_valid & (~in0_valid | ~r_last_grant);

  assign in0_ready = w_accept_ok & w_grant0;
  assign in1_ready = w_accept_ok & w_grant1;
  assign w_accept  = in0_ready | in1_ready;

  assign w_opcode = w_grant1 ? in1_instr[31:26] : in0_instr[31:26];
  assign w_imm16  = w_grant1 ? in1_instr[15:0]  : in0_instr[15:0];
  assign w_unused = ^{in0_instr[25:16], in1_instr[25:16]};

  always_comb begin
    w_ext_imm     = {{16{w_imm16[15]}}, w_imm16};
    w_ext_mode    = MODE_SIGN;
    w_ext_illegal = 1'b0;
    case (w_opcode)
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        w_ext_imm  = {{16{w_imm16[15]}}, w_imm16};
        w_ext_mode = MODE_SIGN;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_ext_imm  = {16'h0000, w_imm16};
        w_ext_mode = MODE_ZERO;
      end
      6'h0F: begin
        w_ext_imm  = {w_imm16, 16'h0000};
        w_ext_mode = MODE_LUI;
      end
      default: begin
        w_ext_illegal = 1'b1;
        w_ext_mode    = MODE_SIGN;
        w_ext_imm     = (ILLEGAL_ZERO != 0) ? 32'h0000_0000
                                            : {{16{w_imm16[15]}}, w_imm16};
      end
    endcase
  end

  // A load while FULL with out_ready is the back-to-back case: the old result
  // leaves on the same edge the new one arrives, so the state stays FULL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_imm        <= 32'h0000_0000;
      r_src        <= 1'b0;
      r_mode       <= MODE_SIGN;
      r_illegal    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state      <= ST_FULL;
        r_last_grant <= in1_ready;
        r_imm        <= w_ext_imm;
        r_src        <= in1_ready;
        r_mode       <= w_ext_mode;
        r_illegal    <= w_ext_illegal;
      end else if ((r_state == ST_FULL) && out_ready) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign out_valid   = (r_state == ST_FULL);
  assign out_imm     = r_imm;
  assign out_src     = r_src;
  assign out_mode    = r_mode;
  assign out_illegal = r_illegal;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Bench for imm_extend_arbiter: directed scenario tasks plus a negedge monitor
// that models arbitration and scoreboards every result in acceptance order.
`timescale 1ns/1ps

module tb_imm_extend_arbiter;

  logic        clk;
  logic        rst;
  logic        in0_valid;
  logic [31:0] in0_instr;
  logic        in0_ready;
  logic        in1_valid;
  logic [31:0] in1_instr;
  logic        in1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_src;
  logic [1:0]  out_mode;
  logic        out_illegal;
  logic        dbg_state;

  logic        z_in0_ready;
  logic        z_in1_ready;
  logic        z_out_valid;
  logic [31:0] z_out_imm;
  logic        z_out_src;
  logic [1:0]  z_out_mode;
  logic        z_out_illegal;
  logic        z_dbg_state;

  int checks;
  int errors;

  // Entry: {src, mode, illegal, imm (ILLEGAL_ZERO=0), imm (ILLEGAL_ZERO=1)}
  logic [67:0] exp_q[$];
  logic        m_full;
  logic        m_last;

  imm_extend_arbiter #(.ILLEGAL_ZERO(0)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_instr(in0_instr), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_instr(in1_instr), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_src(out_src), .out_mode(out_mode), .out_illegal(out_illegal),
    .o_dbg_state(dbg_state)
  );

  imm_extend_arbiter #(.ILLEGAL_ZERO(1)) dut_z (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_instr(in0_instr), .in0_ready(z_in0_ready),
    .in1_valid(in1_valid), .in1_instr(in1_instr), .in1_ready(z_in1_ready),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_imm(z_out_imm),
    .out_src(z_out_src), .out_mode(z_out_mode), .out_illegal(z_out_illegal),
    .o_dbg_state(z_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [67:0] model(input logic s, input logic [31:0] ins);
    logic [5:0]  op;
    logic [15:0] im;
    logic [1:0]  md;
    logic        il;
    logic [31:0] v;
    op = ins[31:26];
    im = ins[15:0];
    il = 1'b0;
    md = 2'b00;
    v  = {{16{im[15]}}, im};
    if (op == 6'h04 || op == 6'h05 || op == 6'h08 || op == 6'h09 ||
        op == 6'h0A || op == 6'h0B || op == 6'h23 || op == 6'h2B) begin
      md = 2'b00;
    end else if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
      md = 2'b01;
      v  = {16'h0000, im};
    end else if (op == 6'h0F) begin
      md = 2'b10;
      v  = {im, 16'h0000};
    end else begin
      il = 1'b1;
    end
    return {s, md, il, v, (il ? 32'h0000_0000 : v)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[16];
    logic [5:0] op;
    ops = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00, 6'h3F, 6'h10, 6'h22};
    op = ops[$urandom_range(0, 15)];
    return {op, 10'($urandom_range(0, 1023)), 16'($urandom_range(0, 65535))};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic        ok, eg0, eg1;
    logic [67:0] e;
    if (!rst) begin
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: ready0=%b ready1=%b out_valid=%b required 0 0 0",
                 in0_ready, in1_ready, out_valid);
      end
      exp_q.delete();
      m_full = 1'b0;
      m_last = 1'b1;
    end else begin
      ok  = !m_full || out_ready;
      eg0 = ok && in0_valid && (!in1_valid || m_last);
      eg1 = ok && in1_valid && (!in0_valid || !m_last);
      checks++;
      if (in0_ready !== eg0 || in1_ready !== eg1 || out_valid !== m_full ||
          z_out_valid !== m_full) begin
        errors++;
        $display("FAIL handshake: ready0=%b ready1=%b out_valid=%b z_valid=%b required %b %b %b %b",
                 in0_ready, in1_ready, out_valid, z_out_valid, eg0, eg1, m_full, m_full);
      end
      if (m_full && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: output handshake with no expected entry");
        end else begin
          e = exp_q.pop_front();
          if ({out_src, out_mode, out_illegal, out_imm, z_out_imm} !== e) begin
            errors++;
            $display("FAIL result: src=%b mode=%b ill=%b imm=%h zimm=%h required src=%b mode=%b ill=%b imm=%h zimm=%h",
                     out_src, out_mode, out_illegal, out_imm, z_out_imm,
                     e[67], e[66:65], e[64], e[63:32], e[31:0]);
          end
        end
      end
      if (eg0 || eg1) begin
        exp_q.push_back(model(eg1, eg1 ? in1_instr : in0_instr));
        m_last = eg1;
        m_full = 1'b1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in0_valid = 1'b1;
    in0_instr = 32'h2008_0001;
    in1_valid = 1'b1;
    in1_instr = 32'h3508_0002;
    out_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_src !== 1'b0 ||
        out_mode !== 2'b00 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%b imm=%h src=%b mode=%b ill=%b required 0 00000000 0 00 0",
               out_valid, out_imm, out_src, out_mode, out_illegal);
    end
    idle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_instr = 32'h2008_FFFC;
    cycle();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_FFFC || out_mode !== 2'b00 ||
        out_src !== 1'b0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi: valid=%b imm=%h mode=%b src=%b ill=%b required 1 fffffffc 00 0 0",
               out_valid, out_imm, out_mode, out_src, out_illegal);
    end
    cycle();
  endtask

  task automatic test_in1_seq();
    out_ready = 1'b1;
    in1_valid = 1'b1;
    in1_instr = 32'h3508_8000;
    cycle();
    in1_instr = 32'h3C08_1234;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h0000_8000 || out_mode !== 2'b01 || out_src !== 1'b1) begin
      errors++;
      $display("FAIL ori: valid=%b imm=%h mode=%b src=%b required 1 00008000 01 1",
               out_valid, out_imm, out_mode, out_src);
    end
    cycle();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h1234_0000 || out_mode !== 2'b10 || out_src !== 1'b1) begin
      errors++;
      $display("FAIL lui: valid=%b imm=%h mode=%b src=%b required 1 12340000 10 1",
               out_valid, out_imm, out_mode, out_src);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_instr = rand_instr();
    in1_instr = rand_instr();
    for (int k = 0; k < 4; k++) begin
      cycle();
      in0_instr = rand_instr();
      in1_instr = rand_instr();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 1'(k % 2)) begin
        errors++;
        $display("FAIL round_robin[%0d]: valid=%b src=%b required 1 %0d",
                 k, out_valid, out_src, k % 2);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_stall();
    logic [67:0] e;
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in0_instr = 32'h2D09_8421;
    cycle();
    e = model(1'b0, 32'h2D09_8421);
    in0_instr = 32'h3109_00FF;
    in1_valid = 1'b1;
    in1_instr = 32'h3C09_ABCD;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_src, out_mode, out_illegal, out_imm} !== e[67:32] ||
          in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b imm=%h ready0=%b ready1=%b required 1 %h 0 0",
                 k, out_valid, out_imm, in0_ready, in1_ready, e[63:32]);
      end
      cycle();
    end
    in1_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h0000_00FF || out_mode !== 2'b01) begin
      errors++;
      $display("FAIL stall_release: valid=%b imm=%h mode=%b required 1 000000ff 01",
               out_valid, out_imm, out_mode);
    end
    cycle();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_instr = 32'h0000_8001;
    cycle();
    idle();
    checks++;
    if (out_illegal !== 1'b1 || out_mode !== 2'b00 || out_imm !== 32'hFFFF_8001 ||
        z_out_illegal !== 1'b1 || z_out_imm !== 32'h0000_0000) begin
      errors++;
      $display("FAIL illegal: ill=%b mode=%b imm=%h zill=%b zimm=%h required 1 00 ffff8001 1 00000000",
               out_illegal, out_mode, out_imm, z_out_illegal, z_out_imm);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      in0_instr = rand_instr();
      in1_instr = rand_instr();
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle();
    out_ready = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in0_instr = 32'h2008_1111;
    cycle();
    idle();
    cycle();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b imm=%h src=%b required 0 00000000 0",
               out_valid, out_imm, out_src);
    end
    out_ready = 1'b1;
    repeat (2) cycle();
    rst = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_instr = 32'h3C08_5555;
    in1_instr = 32'h3C08_AAAA;
    cycle();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_imm !== 32'h5555_0000) begin
      errors++;
      $display("FAIL post_reset_tie: valid=%b src=%b imm=%h required 1 0 55550000",
               out_valid, out_src, out_imm);
    end
    repeat (2) cycle();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    m_full    = 1'b0;
    m_last    = 1'b1;
    rst       = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_instr = 32'h0;
    in1_instr = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_addi();
    test_in1_seq();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_random();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never delivered, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
